// File: rtl/sm_cpu_sequencer.sv
// Multi-cycle Moore control sequencer for the schoolMIPS datapath (fetch/decode/exec/writeback + traps).
// Latency: ADDU/OR/ADDIU 4 cycles, branch 3 cycles, plus one cycle per FETCH wait state.
// Backpressure: stall freezes state, wait counter, latched op and instrCount and masks all write enables.
//
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   cmdOper, cmdFunk         IR opcode / function fields (valid from DECODE)
//   aluZero                  ALU result is zero (branch condition)
//   memReady                 program memory data valid (sampled in FETCH only)
//   stall                    freeze request
//   memRead, irWrite         fetch strobe, IR load enable
//   pcWrite, pcSrc           PC load enable, PC source (0 = ALU, 1 = ALUOut)
//   regWrite, regDst         register write enable, write address select (1 = rd)
//   aluSrcA, aluSrcB         ALU operand selects
//   aluControl               ALU op (000 = ADD, 001 = OR)
//   illegal, busErr          sticky trap causes
//   cycleCount, instrCount   free-running cycle and retired-instruction counters
module sm_cpu_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  cmdOper,
  input  logic [5:0]  cmdFunk,
  input  logic        aluZero,
  input  logic        memReady,
  input  logic        stall,
  output logic        memRead,
  output logic        irWrite,
  output logic        pcWrite,
  output logic        pcSrc,
  output logic        regWrite,
  output logic        regDst,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluControl,
  output logic        illegal,
  output logic        busErr,
  output logic [31:0] cycleCount,
  output logic [31:0] instrCount
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_BRANCH,
    S_TRAP
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_OR    = 6'b100101;

  // Index of the last wait cycle that may still accept memReady.
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t     state_q, state_nxt;
  logic [7:0] wait_q, wait_nxt;
  logic [2:0] op_q, op_nxt;
  logic       set_illegal;
  logic       set_bus_err;
  logic       retire;

  logic       mem_read_raw;
  logic       ir_write_raw;
  logic       pc_write_raw;
  logic       reg_write_raw;

  always_comb begin
    state_nxt     = state_q;
    wait_nxt      = '0;          // cleared unless FETCH keeps waiting
    op_nxt        = op_q;
    set_illegal   = 1'b0;
    set_bus_err   = 1'b0;
    retire        = 1'b0;
    mem_read_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    pc_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    pcSrc         = 1'b0;
    regDst        = 1'b0;
    aluSrcA       = 1'b0;
    aluSrcB       = SRCB_REG;
    aluControl    = ALU_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read_raw = 1'b1;
        aluSrcB      = SRCB_ONE;
        if (memReady) begin
          // memReady wins over a timeout on the same cycle.
          ir_write_raw = 1'b1;
          pc_write_raw = 1'b1;
          state_nxt    = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          set_bus_err = 1'b1;
          state_nxt   = S_TRAP;
        end else begin
          wait_nxt = wait_q + 8'd1;
        end
      end

      S_DECODE: begin
        aluSrcB = SRCB_IMM;
        if (cmdOper == OP_RTYPE && cmdFunk == FN_ADDU) begin
          op_nxt    = ALU_ADD;
          state_nxt = S_EXEC_R;
        end else if (cmdOper == OP_RTYPE && cmdFunk == FN_OR) begin
          op_nxt    = ALU_OR;
          state_nxt = S_EXEC_R;
        end else if (cmdOper == OP_ADDIU) begin
          state_nxt = S_EXEC_I;
        end else if (cmdOper == OP_BEQ) begin
          state_nxt = S_BRANCH;
        end else begin
          set_illegal = 1'b1;
          state_nxt   = S_TRAP;
        end
      end

      S_EXEC_R: begin
        aluSrcA    = 1'b1;
        aluControl = op_q;
        state_nxt  = S_WB_R;
      end

      S_WB_R: begin
        aluSrcA       = 1'b1;
        aluControl    = op_q;
        regDst        = 1'b1;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end

      S_EXEC_I: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        state_nxt = S_WB_I;
      end

      S_WB_I: begin
        aluSrcA       = 1'b1;
        aluSrcB       = SRCB_IMM;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end

      S_BRANCH: begin
        // Branch is taken when rs + rt == 0; target was latched in DECODE.
        aluSrcA      = 1'b1;
        pcSrc        = 1'b1;
        pc_write_raw = aluZero;
        retire       = 1'b1;
        state_nxt    = S_FETCH;
      end

      S_TRAP: begin
        state_nxt = S_TRAP;
      end

      default: begin
        state_nxt = S_TRAP;
      end
    endcase
  end

  // Write enables are masked by stall; reset additionally silences the fetch strobe.
  assign memRead  = mem_read_raw & ~rst;
  assign irWrite  = ir_write_raw & ~stall & ~rst;
  assign pcWrite  = pc_write_raw & ~stall & ~rst;
  assign regWrite = reg_write_raw & ~stall & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_q     <= '0;
      op_q       <= ALU_ADD;
      illegal    <= 1'b0;
      busErr     <= 1'b0;
      cycleCount <= '0;
      instrCount <= '0;
    end else begin
      cycleCount <= cycleCount + 32'd1;
      if (!stall) begin
        state_q <= state_nxt;
        wait_q  <= wait_nxt;
        op_q    <= op_nxt;
        if (set_illegal) illegal <= 1'b1;
        if (set_bus_err) busErr  <= 1'b1;
        if (retire) instrCount <= instrCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_sm_cpu_sequencer.sv
// Directed vector table plus randomized run against an instruction-level reference model.
module tb_sm_cpu_sequencer;

  localparam int TO = 3;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst, stall, memReady, aluZero;
  logic [5:0]  cmdOper, cmdFunk;
  logic        memRead, irWrite, pcWrite, pcSrc, regWrite, regDst, aluSrcA;
  logic [1:0]  aluSrcB;
  logic [2:0]  aluControl;
  logic        illegal, busErr;
  logic [31:0] cycleCount, instrCount;

  sm_cpu_sequencer #(.FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmdOper(cmdOper), .cmdFunk(cmdFunk),
    .aluZero(aluZero), .memReady(memReady), .stall(stall),
    .memRead(memRead), .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc),
    .regWrite(regWrite), .regDst(regDst), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluControl(aluControl), .illegal(illegal), .busErr(busErr),
    .cycleCount(cycleCount), .instrCount(instrCount)
  );

  // {memRead, irWrite, pcWrite, pcSrc, regWrite, regDst, aluSrcA, aluSrcB, aluControl, illegal, busErr}
  logic [13:0] got;
  assign got = {memRead, irWrite, pcWrite, pcSrc, regWrite, regDst, aluSrcA,
                aluSrcB, aluControl, illegal, busErr};

  localparam logic [13:0] E_FW  = 14'b1_0_0_0_0_0_0_01_000_0_0;
  localparam logic [13:0] E_FD  = 14'b1_1_1_0_0_0_0_01_000_0_0;
  localparam logic [13:0] E_RF  = 14'b0_0_0_0_0_0_0_01_000_0_0;
  localparam logic [13:0] E_DEC = 14'b0_0_0_0_0_0_0_10_000_0_0;
  localparam logic [13:0] E_XRA = 14'b0_0_0_0_0_0_1_00_000_0_0;
  localparam logic [13:0] E_XRO = 14'b0_0_0_0_0_0_1_00_001_0_0;
  localparam logic [13:0] E_WRA = 14'b0_0_0_0_1_1_1_00_000_0_0;
  localparam logic [13:0] E_WRO = 14'b0_0_0_0_1_1_1_00_001_0_0;
  localparam logic [13:0] E_XI  = 14'b0_0_0_0_0_0_1_10_000_0_0;
  localparam logic [13:0] E_WI  = 14'b0_0_0_0_1_0_1_10_000_0_0;
  localparam logic [13:0] E_BT  = 14'b0_0_1_1_0_0_1_00_000_0_0;
  localparam logic [13:0] E_BN  = 14'b0_0_0_1_0_0_1_00_000_0_0;
  localparam logic [13:0] E_TI  = 14'b0_0_0_0_0_0_0_00_000_1_0;
  localparam logic [13:0] E_TB  = 14'b0_0_0_0_0_0_0_00_000_0_1;
  localparam logic [13:0] M_ALL = 14'h3fff;
  localparam logic [13:0] M_EN  = 14'b1_1_1_0_1_0_0_00_000_0_0;

  // {rst, stall, memReady, aluZero}
  localparam logic [3:0] I_N   = 4'b0000;
  localparam logic [3:0] I_RDY = 4'b0010;
  localparam logic [3:0] I_Z   = 4'b0001;
  localparam logic [3:0] I_STL = 4'b0100;
  localparam logic [3:0] I_RST = 4'b1000;

  localparam logic [5:0] Z6  = 6'b000000;
  localparam logic [5:0] OPI = 6'b001001;
  localparam logic [5:0] OPB = 6'b000100;
  localparam logic [5:0] OPL = 6'b100011;
  localparam logic [5:0] FAD = 6'b100001;
  localparam logic [5:0] FOR = 6'b100101;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [5:0]  oper;
    logic [5:0]  funk;
    logic [13:0] exp;
    logic [13:0] mask;
    logic        chk;
    logic [31:0] cyc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t r(input logic [3:0] ctl, input logic [5:0] oper,
                             input logic [5:0] funk, input logic [13:0] exp);
    vec_t v;
    v.ctl = ctl; v.oper = oper; v.funk = funk; v.exp = exp;
    v.mask = M_ALL; v.chk = 1'b0; v.cyc = '0; v.ins = '0;
    return v;
  endfunction

  function automatic vec_t c(input vec_t v, input logic [31:0] cyc, input logic [31:0] ins);
    vec_t o;
    o = v; o.chk = 1'b1; o.cyc = cyc; o.ins = ins;
    return o;
  endfunction

  task automatic drive(input logic [3:0] ctl, input logic [5:0] oper, input logic [5:0] funk);
    {rst, stall, memReady, aluZero} = ctl;
    cmdOper = oper;
    cmdFunk = funk;
  endtask

  task automatic chk14(input string name, input int idx, input logic [13:0] g,
                       input logic [13:0] e, input logic [13:0] m);
    n_cmp++;
    if ((g & m) !== (e & m)) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %b want %b", name, idx, g & m, e & m);
    end
  endtask

  task automatic chk32(input string name, input int idx, input logic [31:0] g, input logic [31:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, g, e);
    end
  endtask

  // Reference model state: position within the current instruction, not a state encoding.
  int          m_step, m_kind, m_waits, m_trap;   // kind 0=R 1=I 2=branch; trap 0=none 1=illegal 2=bus
  logic [2:0]  m_op;
  logic [31:0] m_cyc, m_ins;
  logic        mr, irw, pcw, pcs, rw, rd, sa;
  logic [1:0]  sb;
  logic [2:0]  ac;
  logic [3:0]  rctl;
  logic [5:0]  ropr, rfnk;

  initial begin
    // Reset, then the four basic instructions with zero wait states.
    tbl.push_back(r(I_RST, Z6, Z6, 14'b0));
    tbl[0].mask = M_EN;
    tbl.push_back(r(I_RST, Z6, Z6, E_RF));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   Z6, FAD, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_XRA));
    tbl.push_back(r(I_N,   Z6, Z6, E_WRA));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   OPI, Z6, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_XI));
    tbl.push_back(r(I_N,   Z6, Z6, E_WI));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   Z6, FOR, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_XRO));
    tbl.push_back(r(I_N,   Z6, Z6, E_WRO));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   OPB, Z6, E_DEC));
    tbl.push_back(r(I_Z,   Z6, Z6, E_BT));
    // Not-taken branch still retires.
    tbl.push_back(c(r(I_RDY, Z6, Z6, E_FD), 15, 4));
    tbl.push_back(r(I_N,   OPB, Z6, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_BN));
    // memReady on the last permitted wait cycle completes normally.
    tbl.push_back(c(r(I_N, Z6, Z6, E_FW), 18, 5));
    tbl.push_back(r(I_N,   Z6, Z6, E_FW));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   OPI, Z6, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_XI));
    tbl.push_back(r(I_N,   Z6, Z6, E_WI));
    // Two stalled cycles in EXEC_R.
    tbl.push_back(c(r(I_RDY, Z6, Z6, E_FD), 24, 6));
    tbl.push_back(r(I_N,   Z6, FAD, E_DEC));
    tbl.push_back(r(I_STL, Z6, Z6, E_XRA));
    tbl.push_back(r(I_STL, Z6, Z6, E_XRA));
    tbl.push_back(r(I_N,   Z6, Z6, E_XRA));
    tbl.push_back(r(I_N,   Z6, Z6, E_WRA));
    // Reset during WB_I suppresses the write and clears the counters.
    tbl.push_back(c(r(I_RDY, Z6, Z6, E_FD), 30, 7));
    tbl.push_back(r(I_N,   OPI, Z6, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_XI));
    tbl.push_back(r(I_RST, Z6, Z6, E_XI));
    // Illegal opcode trap, cleared by reset.
    tbl.push_back(c(r(I_N, Z6, Z6, E_FW), 0, 0));
    tbl.push_back(r(I_RDY, Z6, Z6, E_FD));
    tbl.push_back(r(I_N,   OPL, Z6, E_DEC));
    tbl.push_back(r(I_N,   Z6, Z6, E_TI));
    tbl.push_back(r(I_RDY, OPI, Z6, E_TI));
    tbl.push_back(r(I_RST, Z6, Z6, E_TI));
    // Fetch timeout; a stalled wait cycle does not count.
    tbl.push_back(c(r(I_N, Z6, Z6, E_FW), 0, 0));
    tbl.push_back(r(I_STL, Z6, Z6, E_FW));
    tbl.push_back(r(I_N,   Z6, Z6, E_FW));
    tbl.push_back(r(I_N,   Z6, Z6, E_FW));
    tbl.push_back(r(I_N,   Z6, Z6, E_TB));
    tbl.push_back(c(r(I_RDY, Z6, Z6, E_TB), 5, 0));
    tbl.push_back(r(I_RST, Z6, Z6, E_TB));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].ctl, tbl[i].oper, tbl[i].funk);
      @(negedge clk);
      chk14("vec", i, got, tbl[i].exp, tbl[i].mask);
      if (tbl[i].chk) begin
        chk32("vec_cycleCount", i, cycleCount, tbl[i].cyc);
        chk32("vec_instrCount", i, instrCount, tbl[i].ins);
      end
      @(posedge clk);
      #1;
    end

    // Randomized run; the last table row left the DUT freshly reset.
    m_step = 0; m_kind = 0; m_waits = 0; m_trap = 0; m_op = 3'b000;
    m_cyc = '0; m_ins = '0;
    for (int k = 0; k < 3000; k++) begin
      rctl[3] = (m_trap != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      rctl[2] = ($urandom_range(0, 9) == 0);
      rctl[1] = ($urandom_range(0, 9) < 6);
      rctl[0] = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 9))
        0, 1, 2: begin ropr = Z6;  rfnk = FAD; end
        3, 4:    begin ropr = Z6;  rfnk = FOR; end
        5, 6:    begin ropr = OPI; rfnk = 6'($urandom); end
        7, 8:    begin ropr = OPB; rfnk = 6'($urandom); end
        default: begin ropr = 6'($urandom); rfnk = 6'($urandom); end
      endcase
      drive(rctl, ropr, rfnk);

      mr = 0; irw = 0; pcw = 0; pcs = 0; rw = 0; rd = 0; sa = 0; sb = 2'b00; ac = 3'b000;
      if (m_trap == 0) begin
        if (m_step == 0) begin
          mr = 1; sb = 2'b01; irw = memReady; pcw = memReady;
        end else if (m_step == 1) begin
          sb = 2'b10;
        end else if (m_kind == 0) begin
          sa = 1; ac = m_op; rd = (m_step == 3); rw = (m_step == 3);
        end else if (m_kind == 1) begin
          sa = 1; sb = 2'b10; rw = (m_step == 3);
        end else begin
          sa = 1; pcs = 1; pcw = aluZero;
        end
      end
      if (stall) begin irw = 0; pcw = 0; rw = 0; end
      if (rst) begin mr = 0; irw = 0; pcw = 0; rw = 0; end

      @(negedge clk);
      chk14("rnd", k, got, {mr, irw, pcw, pcs, rw, rd, sa, sb, ac, m_trap == 1, m_trap == 2}, M_ALL);
      chk32("rnd_cycleCount", k, cycleCount, m_cyc);
      chk32("rnd_instrCount", k, instrCount, m_ins);

      if (rst) begin
        m_step = 0; m_waits = 0; m_trap = 0; m_op = 3'b000; m_cyc = '0; m_ins = '0;
      end else begin
        m_cyc = m_cyc + 1;
        if (!stall && m_trap == 0) begin
          if (m_step == 0) begin
            if (memReady) begin
              m_step = 1; m_waits = 0;
            end else if (m_waits + 1 == TO) begin
              m_trap = 2;
            end else begin
              m_waits++;
            end
          end else if (m_step == 1) begin
            if (cmdOper == Z6 && cmdFunk == FAD)      begin m_kind = 0; m_op = 3'b000; m_step = 2; end
            else if (cmdOper == Z6 && cmdFunk == FOR) begin m_kind = 0; m_op = 3'b001; m_step = 2; end
            else if (cmdOper == OPI)                  begin m_kind = 1; m_step = 2; end
            else if (cmdOper == OPB)                  begin m_kind = 2; m_step = 2; end
            else m_trap = 1;
          end else if (m_step == 2 && m_kind == 2) begin
            m_ins = m_ins + 1; m_step = 0; m_waits = 0;
          end else if (m_step == 2) begin
            m_step = 3;
          end else begin
            m_ins = m_ins + 1; m_step = 0; m_waits = 0;
          end
        end
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sm_cpu_sequencer.md
# sm_cpu_sequencer

Multi-cycle control sequencer for the schoolMIPS datapath. It replaces the single-cycle combinational decoder when the core shares one ALU across fetch, address and execute steps and fetches from wait-stated program memory. It is a Moore FSM that drives the PC, IR and register-file write enables, the ALU operand and operation selects, and the memory read strobe. It also keeps cycle and retired-instruction counters, and traps on illegal opcodes and fetch timeouts.

## Interface
Parameters:
- FETCH_TIMEOUT, 15: maximum FETCH wait cycles without memReady before bus-error trap; legal range 1..255.

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- cmdOper  in  6  IR[31:26]; valid from DECODE onward
- cmdFunk  in  6  IR[5:0]
- aluZero  in  1  ALU result == 0
- memReady  in  1  program memory data valid this cycle
- stall  in  1  freeze request (debug/step)
- memRead  out  1  instruction fetch strobe
- irWrite  out  1  load IR from memory data
- pcWrite  out  1  load PC
- pcSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut register (branch target)
- regWrite  out  1  register-file write enable
- regDst  out  1  write address: 1 = rd (IR[15:11]), 0 = rt (IR[20:16])
- aluSrcA  out  1  0 = PC, 1 = A (rs register)
- aluSrcB  out  2  00 = B (rt register), 01 = constant 1, 10 = signImm
- aluControl  out  3  000 = ADD, 001 = OR
- illegal  out  1  sticky: illegal instruction trap
- busErr  out  1  sticky: fetch timeout trap
- cycleCount  out  32  cycles since reset
- instrCount  out  32  retired instructions since reset

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, WB_R, WB_I, BRANCH, TRAP.
- Outputs are decoded from state only, except the FETCH-completion and BRANCH enables (depend on memReady / aluZero).
- Default for every output not listed in a state: 0.
- FETCH:
  - memRead = 1; aluSrcA = 0, aluSrcB = 01, ADD (computes PC + 1; PC is word-addressed).
  - On memReady: irWrite = 1, pcWrite = 1, pcSrc = 0, then go to DECODE.
  - Otherwise the wait counter increments. When the count equals FETCH_TIMEOUT, set busErr and go to TRAP.
- DECODE:
  - aluSrcA = 0, aluSrcB = 10, ADD; the datapath latches the branch target into ALUOut.
  - Next state by {cmdOper, cmdFunk}:
    - 000000/100001 (ADDU) → EXEC_R with ADD
    - 000000/100101 (OR) → EXEC_R with OR
    - 001001 (ADDIU) → EXEC_I
    - 000100 (branch) → BRANCH
    - anything else: set illegal, go to TRAP.
  - The R-type ALU op is held in a 3-bit register for EXEC_R/WB_R.
- EXEC_R: aluSrcA = 1, aluSrcB = 00, latched op → WB_R.
- WB_R: same ALU selects; regDst = 1, regWrite = 1 → FETCH.
- EXEC_I: aluSrcA = 1, aluSrcB = 10, ADD → WB_I.
- WB_I: same ALU selects; regDst = 0, regWrite = 1 → FETCH.
- BRANCH: aluSrcA = 1, aluSrcB = 00, ADD; pcSrc = 1, pcWrite = aluZero → FETCH. The branch condition is rs + rt == 0.
- TRAP: absorbing state. All enables are 0 and memRead is 0. Only rst exits.
- stall = 1:
  - State, wait counter, latched op and instrCount hold.
  - pcWrite, irWrite and regWrite are forced to 0; select outputs keep their state values.
  - A stall during a FETCH wait does not advance the timeout.
- Counters:
  - cycleCount increments every cycle with rst = 0, including stall and TRAP.
  - instrCount increments on the non-stalled cycle in WB_R, WB_I or BRANCH.
  - Both counters wrap modulo 2^32.

## Timing
- Reset: while rst = 1, every enable output is 0 and memRead is 0.
- State after a reset edge: FETCH. Wait counter, latched op, illegal, busErr and both counters are all 0.
- The first post-reset cycle asserts memRead.
- Reset mid-instruction abandons the instruction; no register or PC write occurs in the rst cycle.
- Latency with zero wait states (memReady in the first FETCH cycle):
  - ADDU/OR/ADDIU: 4 cycles.
  - Branch: 3 cycles.
  - Each FETCH wait cycle adds 1.
- memReady is sampled only in FETCH and ignored elsewhere.
- The wait counter clears on entry to FETCH.
- FETCH_TIMEOUT = N:
  - memReady arriving on wait cycle N-1 (0-based) still completes normally.
  - Without memReady, the trap is taken on the edge ending wait cycle N-1.
  - busErr is visible on the following cycle.
- memReady and the timeout on the same cycle: memReady wins.
- illegal and busErr are mutually exclusive; the first trap cause wins.

## Test plan
- ADDU, ADDIU, OR, taken branch, each with memReady tied 1 → per-state outputs match Operation.
  - Checks: regWrite in cycle 4 only; taken-branch pcWrite with pcSrc = 1 in cycle 3.
  - After 4 instructions: instrCount = 4, cycleCount = 15.
- Branch with aluZero = 0 → pcWrite = 0 in BRANCH, FETCH next, instrCount still increments.
- FETCH_TIMEOUT = 3:
  - memReady on the 3rd FETCH cycle → normal DECODE.
  - Rerun with memReady held 0 → TRAP after 3 wait cycles, busErr = 1, memRead = 0 thereafter, instrCount frozen.
- cmdOper = 100011 in DECODE → illegal = 1, TRAP. A subsequent rst pulse clears illegal, and the state returns to FETCH with memRead = 1.
- stall held 2 cycles in EXEC_R → state holds, no enables asserted, then WB_R with regWrite = 1. cycleCount advances by 2 extra, instrCount does not.
- rst asserted during WB_I → regWrite = 0 that cycle, next state FETCH, both counters 0.
